// File: rtl/word_rx_pkg.sv
// Shared types and helpers for the serial word receiver.
// Optional parity checking is selected by WORD_RECEIVER_PARITY_EN.
package word_rx_pkg;

    typedef enum logic {
        SHIFT  = 1'b0,
        PARITY = 1'b1
    } rx_state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// Single-entry valid/ready output buffer for word_receiver.
// Tracks drop (overrun) and the parity status of the buffered word.
module rx_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             parity_in,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             overrun,
    output logic             parity_err
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else if (load) begin
            // A full buffer being consumed this edge still accepts the new word.
            if (!valid || ready) begin
                out        <= word;
                valid      <= 1'b1;
                parity_err <= parity_in;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_receiver.sv
// MSB-first serial-to-parallel receiver with a single-entry output buffer.
// Define WORD_RECEIVER_PARITY_EN to expect an even-parity bit after each word.
module word_receiver
    import word_rx_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             clear,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count,
    output logic             parity_err
);

    rx_state_t        state, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next, word_shifted, load_word;
    logic [CW-1:0]    count_next;
    logic             load, load_parity;

    assign word_shifted = {shift_reg[WIDTH-2:0], in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_count <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        count_next  = bit_count;
        load        = 1'b0;
        load_word   = word_shifted;
        load_parity = 1'b0;
        if (clear) begin
            state_next = SHIFT;
            shift_next = '0;
            count_next = '0;
        end else if (enable) begin
            case (state)
                SHIFT: begin
                    shift_next = word_shifted;
                    if (bit_count == CW'(WIDTH - 1)) begin
                        count_next = '0;
`ifdef WORD_RECEIVER_PARITY_EN
                        state_next = PARITY;
`else
                        load       = 1'b1;
`endif
                    end else begin
                        count_next = bit_count + CW'(1);
                    end
                end
`ifdef WORD_RECEIVER_PARITY_EN
                PARITY: begin
                    // The completed word waits in shift_reg for its parity bit.
                    load        = 1'b1;
                    load_word   = shift_reg;
                    load_parity = even_parity(64'(shift_reg)) ^ in;
                    state_next  = SHIFT;
                end
`endif
                default: state_next = SHIFT;
            endcase
        end
    end

    rx_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .word      (load_word),
        .parity_in (load_parity),
        .ready     (ready),
        .out       (out),
        .valid     (valid),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

endmodule
